// File: rtl/fifo_axis_pkg.sv
// Shared definitions for the single- and dual-clock AXI-Stream FIFOs.
// A stored beat is packed MSB to LSB as {TLAST, TUSER, TKEEP, TDATA}.
package fifo_axis_pkg;

  function automatic int unsigned beat_width(int unsigned data_width, int unsigned user_width);
    return data_width + data_width / 8 + user_width + 1;
  endfunction

  function automatic int unsigned keep_lsb(int unsigned data_width);
    return data_width;
  endfunction

  function automatic int unsigned user_lsb(int unsigned data_width);
    return data_width + data_width / 8;
  endfunction

  function automatic int unsigned last_bit(int unsigned data_width, int unsigned user_width);
    return data_width + data_width / 8 + user_width;
  endfunction

endpackage

// File: rtl/fifo_sync_ram.sv
// Simple dual-port memory: synchronous write port, asynchronous read port.
module fifo_sync_ram #(
  parameter int unsigned Width = 20,
  parameter int unsigned Depth = 16
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(Depth)-1:0] waddr_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic [$clog2(Depth)-1:0] raddr_i,
  output logic [Width-1:0]         rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_in_sync_tuser_pkt.sv
// Single-clock AXI-Stream FIFO (FWFT) with occupancy counters and an optional
// store-and-forward mode that holds output until a whole packet is stored.
module fifo_in_sync_tuser_pkt
  import fifo_axis_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned USER_WIDTH  = 1,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned PACKET_MODE = 0
) (
  input  logic                    S_AXIS_CLK,
  input  logic                    S_AXIS_RESET,
  input  logic [DATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic [DATA_WIDTH/8-1:0] S_AXIS_TKEEP,
  input  logic [USER_WIDTH-1:0]   S_AXIS_TUSER,
  input  logic                    S_AXIS_TLAST,
  input  logic                    S_AXIS_TVALID,
  output logic                    S_AXIS_TREADY,
  output logic [DATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [DATA_WIDTH/8-1:0] M_AXIS_TKEEP,
  output logic [USER_WIDTH-1:0]   M_AXIS_TUSER,
  output logic                    M_AXIS_TLAST,
  output logic                    M_AXIS_TVALID,
  input  logic                    M_AXIS_TREADY,
  output logic [$clog2(DEPTH):0]  DATA_COUNT,
  output logic [$clog2(DEPTH):0]  PKT_COUNT
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned CW      = AW + 1;
  localparam int unsigned KW      = DATA_WIDTH / 8;
  localparam int unsigned BW      = beat_width(DATA_WIDTH, USER_WIDTH);
  localparam int unsigned KeepLsb = keep_lsb(DATA_WIDTH);
  localparam int unsigned UserLsb = user_lsb(DATA_WIDTH);
  localparam int unsigned LastBit = last_bit(DATA_WIDTH, USER_WIDTH);
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  logic [CW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] data_count_q, data_count_d, pkt_count_q, pkt_count_d;
  logic [BW-1:0] wr_beat, rd_beat;
  logic          full, wr_en, rd_en, m_valid, wr_last, rd_last;

  // Ready depends on the registered count only; a same-cycle read does not free a slot.
  assign full          = (data_count_q == FullCount);
  assign S_AXIS_TREADY = ~full & ~S_AXIS_RESET;
  assign wr_en         = S_AXIS_TVALID & S_AXIS_TREADY;
  assign wr_beat       = {S_AXIS_TLAST, S_AXIS_TUSER, S_AXIS_TKEEP, S_AXIS_TDATA};

  // The full escape lets a packet longer than the FIFO drain instead of deadlocking.
  if (PACKET_MODE != 0) begin : g_store_fwd
    assign m_valid = (data_count_q != '0) & ((pkt_count_q != '0) | full);
  end else begin : g_cut_through
    assign m_valid = (data_count_q != '0);
  end

  assign rd_en   = m_valid & M_AXIS_TREADY;
  assign wr_last = wr_en & S_AXIS_TLAST;
  assign rd_last = rd_en & rd_beat[LastBit];

  fifo_sync_ram #(
    .Width (BW),
    .Depth (DEPTH)
  ) u_ram (
    .clk_i   (S_AXIS_CLK),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (wr_beat),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rd_beat)
  );

  always_comb begin
    M_AXIS_TVALID = m_valid;
    M_AXIS_TDATA  = '0;
    M_AXIS_TKEEP  = '0;
    M_AXIS_TUSER  = '0;
    M_AXIS_TLAST  = 1'b0;
    if (m_valid) begin
      M_AXIS_TDATA = rd_beat[DATA_WIDTH-1:0];
      M_AXIS_TKEEP = rd_beat[KeepLsb +: KW];
      M_AXIS_TUSER = rd_beat[UserLsb +: USER_WIDTH];
      M_AXIS_TLAST = rd_beat[LastBit];
    end
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q + CW'(wr_en);
    rd_ptr_d     = rd_ptr_q + CW'(rd_en);
    data_count_d = data_count_q;
    pkt_count_d  = pkt_count_q;
    case ({wr_en, rd_en})
      2'b10:   data_count_d = data_count_q + CW'(1);
      2'b01:   data_count_d = data_count_q - CW'(1);
      default: data_count_d = data_count_q;
    endcase
    case ({wr_last, rd_last})
      2'b10:   pkt_count_d = pkt_count_q + CW'(1);
      2'b01:   pkt_count_d = pkt_count_q - CW'(1);
      default: pkt_count_d = pkt_count_q;
    endcase
  end

  always_ff @(posedge S_AXIS_CLK) begin
    if (S_AXIS_RESET) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      data_count_q <= '0;
      pkt_count_q  <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      data_count_q <= data_count_d;
      pkt_count_q  <= pkt_count_d;
    end
  end

  assign DATA_COUNT = data_count_q;
  assign PKT_COUNT  = pkt_count_q;

endmodule

// File: tb/tb_fifo_in_sync_tuser_pkt.sv
// Bench: cut-through (dut 0) and store-and-forward (dut 1) instances checked
// every cycle against a count model plus a per-instance expected-beat queue.
module tb_fifo_in_sync_tuser_pkt;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]        sv, mr;
  logic [15:0]       sd;
  logic [1:0]        sk;
  logic              su, sl;
  logic [1:0]        s_rdy, m_vld, m_user, m_last;
  logic [1:0][15:0]  m_data;
  logic [1:0][1:0]   m_keep;
  logic [1:0][4:0]   dcnt, pcnt;

  int          total = 0;
  int          bad = 0;
  int          cnt[2];
  int          pkt[2];
  bit          acc[2];
  bit          chk_on = 1'b0;
  logic [19:0] q0[$];
  logic [19:0] q1[$];

  fifo_in_sync_tuser_pkt #(
    .DATA_WIDTH(16), .USER_WIDTH(1), .DEPTH(DEPTH), .PACKET_MODE(0)
  ) dut_ct (
    .S_AXIS_CLK(clk), .S_AXIS_RESET(rst), .S_AXIS_TDATA(sd), .S_AXIS_TKEEP(sk),
    .S_AXIS_TUSER(su), .S_AXIS_TLAST(sl), .S_AXIS_TVALID(sv[0]), .S_AXIS_TREADY(s_rdy[0]),
    .M_AXIS_TDATA(m_data[0]), .M_AXIS_TKEEP(m_keep[0]), .M_AXIS_TUSER(m_user[0]),
    .M_AXIS_TLAST(m_last[0]), .M_AXIS_TVALID(m_vld[0]), .M_AXIS_TREADY(mr[0]),
    .DATA_COUNT(dcnt[0]), .PKT_COUNT(pcnt[0])
  );

  fifo_in_sync_tuser_pkt #(
    .DATA_WIDTH(16), .USER_WIDTH(1), .DEPTH(DEPTH), .PACKET_MODE(1)
  ) dut_pk (
    .S_AXIS_CLK(clk), .S_AXIS_RESET(rst), .S_AXIS_TDATA(sd), .S_AXIS_TKEEP(sk),
    .S_AXIS_TUSER(su), .S_AXIS_TLAST(sl), .S_AXIS_TVALID(sv[1]), .S_AXIS_TREADY(s_rdy[1]),
    .M_AXIS_TDATA(m_data[1]), .M_AXIS_TKEEP(m_keep[1]), .M_AXIS_TUSER(m_user[1]),
    .M_AXIS_TLAST(m_last[1]), .M_AXIS_TVALID(m_vld[1]), .M_AXIS_TREADY(mr[1]),
    .DATA_COUNT(dcnt[1]), .PKT_COUNT(pcnt[1])
  );

  task automatic chk(input string tag, input int d, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  // Check all outputs against the model, then advance the model and the clock.
  task automatic step();
    #1;
    if (chk_on) begin
      for (int d = 0; d < 2; d++) begin
        logic [19:0] front, obs;
        bit er, ev, wr, rd;
        front = 20'h0;
        if (d == 0 && q0.size() > 0) front = q0[0];
        if (d == 1 && q1.size() > 0) front = q1[0];
        er  = !rst && cnt[d] != DEPTH;
        ev  = cnt[d] != 0 && (d == 0 || pkt[d] != 0 || cnt[d] == DEPTH);
        obs = {m_last[d], m_user[d], m_keep[d], m_data[d]};
        chk("s_tready", d, 32'(s_rdy[d]), 32'(er));
        chk("m_tvalid", d, 32'(m_vld[d]), 32'(ev));
        chk("data_count", d, 32'(dcnt[d]), 32'(cnt[d]));
        chk("pkt_count", d, 32'(pcnt[d]), 32'(pkt[d]));
        chk("m_beat", d, 32'(obs), ev ? 32'(front) : 32'h0);
        wr = sv[d] && er;
        rd = ev && mr[d];
        acc[d] = wr;
        if (rd) begin
          if (d == 0) void'(q0.pop_front());
          else        void'(q1.pop_front());
          cnt[d]--;
          pkt[d] -= int'(front[19]);
        end
        if (wr) begin
          if (d == 0) q0.push_back({sl, su, sk, sd});
          else        q1.push_back({sl, su, sk, sd});
          cnt[d]++;
          pkt[d] += int'(sl);
        end
        if (rst) begin
          cnt[d] = 0;
          pkt[d] = 0;
          acc[d] = 1'b0;
          if (d == 0) q0.delete();
          else        q1.delete();
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input logic [15:0] data, input logic [1:0] keep,
                      input logic user, input logic last, output int waited);
    sd = data; sk = keep; su = user; sl = last;
    sv[d] = 1'b1;
    waited = 0;
    acc[d] = 1'b0;
    while (!acc[d] && waited < 64) begin
      step();
      if (!acc[d]) waited++;
    end
    chk("accept_timeout", d, 32'(acc[d]), 32'h1);
    sv[d] = 1'b0;
  endtask

  task automatic drain();
    int n;
    sv = 2'b00;
    mr = 2'b11;
    n = 0;
    while ((cnt[0] != 0 || cnt[1] != 0) && n < 200) begin
      step();
      n++;
    end
    step();
    chk("drain_timeout", 0, 32'(cnt[0] + cnt[1]), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst = 1'b1; sv = 2'b00; mr = 2'b00;
    sd = '0; sk = '0; su = 1'b0; sl = 1'b0;
    cnt = '{0, 0}; pkt = '{0, 0}; acc = '{1'b0, 1'b0};
    @(posedge clk); #1;
    step();
    chk_on = 1'b1;
    step();
    rst = 1'b0;
    step();

    // Single beat held with TREADY low, then released.
    sv = 2'b11; sd = 16'hA5A5; sk = 2'b11; su = 1'b1; sl = 1'b1;
    step();
    sv = 2'b00;
    repeat (3) step();
    mr = 2'b11;
    step();
    drain();

    // Fill cut-through instance to DEPTH; 17th beat must wait.
    mr = 2'b00;
    for (int i = 0; i < DEPTH; i++) send(0, 16'(16'h100 + i), 2'(i), 1'(i), 1'b0, w);
    sv[0] = 1'b1; sd = 16'hBEEF; sk = 2'b01; su = 1'b0; sl = 1'b1;
    step();
    chk("full_reject", 0, 32'(acc[0]), 32'h0);
    step();
    mr[0] = 1'b1;
    step();
    chk("full_reject_on_read", 0, 32'(acc[0]), 32'h0);
    mr[0] = 1'b0;
    step();
    chk("accept_after_read", 0, 32'(acc[0]), 32'h1);
    sv[0] = 1'b0;
    drain();

    // Streaming at one beat per cycle with pointer wrap.
    mr = 2'b01;
    for (int i = 0; i < 1000; i++) begin
      send(0, 16'(i * 37), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'(i % 8 == 7), w);
      chk("throughput", 0, 32'(w), 32'h0);
    end
    drain();

    // Store-and-forward: 5-beat packet into a ready sink.
    mr = 2'b10;
    for (int i = 0; i < 5; i++) send(1, 16'(16'h500 + i), 2'b11, 1'(i == 0), 1'(i == 4), w);
    repeat (6) step();
    drain();

    // Store-and-forward: 20-beat packet longer than the FIFO drains via full escape.
    mr = 2'b10;
    for (int i = 0; i < 20; i++) send(1, 16'(16'h2000 + i), 2'(i), 1'(i == 0), 1'(i == 19), w);
    drain();

    // Reset mid-packet with seven beats stored.
    mr = 2'b00;
    sv = 2'b11; sk = 2'b11; su = 1'b0; sl = 1'b0;
    for (int i = 0; i < 7; i++) begin
      sd = 16'(16'h700 + i);
      step();
    end
    sv = 2'b00;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    send(0, 16'h1234, 2'b10, 1'b1, 1'b1, w);
    send(1, 16'h4321, 2'b01, 1'b0, 1'b1, w);
    step();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
